fp64_to_int_iter: RTL and testbench
===================================

FP64_TO_INT_ITER -- requirements
Module: fp64_to_int_iter

Interface
REQ-001 Parameters SHALL be:
  - OUT_W, default 64: signed integer result width, legal range 8..64.
  - STEP, default 8: maximum shift distance applied per cycle, legal range 1..16.
REQ-002 Ports SHALL be:
  - clock  in  1  sole clock; all state updates on its rising edge.
  - reset  in  1  synchronous, active-high reset.
  - in_valid  in  1  in_bits holds an operand.
  - in_ready  out  1  block can accept an operand.
  - in_bits  in  64  IEEE-754 binary64 bit pattern.
  - out_valid  out  1  result and flags are valid.
  - out_ready  in  1  consumer accepts the result.
  - out_bits  out  OUT_W  two's-complement result, truncated toward zero.
  - out_overflow  out  1  result saturated: out of range or infinity.
  - out_invalid  out  1  operand was NaN.
  - out_inexact  out  1  nonzero fraction bits were discarded.

Function
REQ-003 Operand acceptance SHALL occur in a cycle with in_valid=1 and in_ready=1 (C0); in_ready SHALL be 1 only in state IDLE.
REQ-004 The state machine SHALL have states IDLE, SHIFT and DONE:
  - IDLE->SHIFT on acceptance of a normal operand.
  - IDLE->DONE on acceptance of a special operand.
  - SHIFT->DONE when the remaining shift count is 0.
  - DONE->IDLE when out_ready=1.
REQ-005 Unpacking at C0 SHALL be: s=bit63, ex=bits62:52, fr=bits51:0, e=ex-1023, m={1,fr} (53 bits).
REQ-006 Special operands SHALL resolve directly to DONE with these results:
  - ex=2047 with fr!=0 (NaN): 0, invalid=1.
  - ex=2047 with fr=0 (infinity): saturate per sign, overflow=1.
  - ex=0 (zero or subnormal): 0, inexact=(fr!=0).
  - e<0: 0, inexact=1.
  - e>=OUT_W-1: saturate per sign, overflow=1.
  - Exception to the previous case: s=1, e=OUT_W-1 and fr=0 SHALL give -2^(OUT_W-1) with no flags.
REQ-007 Saturation values SHALL be 2^(OUT_W-1)-1 for s=0 and -2^(OUT_W-1) for s=1.
REQ-008 For a normal operand (0<=e<OUT_W-1), the magnitude SHALL be m shifted left by e-52 if e>=52, otherwise right by 52-e.
REQ-009 The accumulator SHALL be max(53,OUT_W) bits wide. Each SHIFT cycle with remaining count r>0 SHALL shift by min(STEP,r) and decrement r by that amount.
REQ-010 During a right shift, any 1 bit shifted out SHALL set a sticky inexact flag.
REQ-011 In the SHIFT cycle with r=0, the block SHALL negate the magnitude when s=1, then enter DONE.
REQ-012 Latency SHALL be as follows:
  - Special operand: out_valid=1 in cycle C1.
  - Normal operand: out_valid=1 in cycle C(k+2), where k=ceil(shift/STEP).
REQ-013 out_valid SHALL be 1 exactly in DONE.
REQ-014 out_bits and all flags SHALL hold stable while out_valid=1 and out_ready=0.
REQ-015 The block SHALL process one operand at a time. An operand presented while in_ready=0 SHALL NOT be consumed.
REQ-016 Because in_ready=0 in DONE, the DONE->IDLE handoff SHALL cost one bubble cycle.
REQ-017 out_bits and all flags SHALL read 0 whenever out_valid=0.

Reset
REQ-018 While reset=1 at a clock edge, the block SHALL enter IDLE and clear the accumulator, the shift count and all flags.
REQ-019 After reset: in_ready=1, out_valid=0, out_bits=0, all flags=0.
REQ-020 A reset during SHIFT or DONE SHALL discard the in-flight operand with no output produced.

Structure
REQ-021 A shared package SHALL hold:
  - the binary64 field constants (EXP_W=11, FRAC_W=52, BIAS=1023);
  - the state enumeration;
  - the flag-bundle typedef.
REQ-022 A combinational sub-module, fp64_unpack, SHALL perform field extraction, special-case classification and shift-direction/count computation. fp64_to_int_iter SHALL hold all sequential logic.

Verification (OUT_W=64, STEP=8; out_ready=1 unless stated)
REQ-023 Operand 0x3FF0000000000000 (1.0) -> out_bits=1, no flags, out_valid in C9 (k=7).
REQ-024 Operand 0xC004000000000000 (-2.5) -> out_bits=0xFFFFFFFFFFFFFFFE, inexact=1.
REQ-025 Operands:
  - 0x7FF8000000000000 -> 0, invalid=1, out_valid in C1.
  - 0x43E0000000000000 -> 0x7FFFFFFFFFFFFFFF, overflow=1.
  - 0xC3E0000000000000 -> 0x8000000000000000, no flags.
REQ-026 Operand 0x43D0000000000000 (2^62) -> 0x4000000000000000, out_valid in C4 (left shift 10, k=2).
REQ-027 out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0; raising out_ready -> IDLE next cycle, in_ready=1.
REQ-028 reset asserted in cycle C3 of a 1.0 conversion -> in_ready=1 and out_valid=0 next cycle; a following operand converts correctly.

Source files
------------

// File: rtl/fp64_to_int_iter_pkg.sv
// Shared definitions for the iterative binary64 -> signed integer converter.
// Holds the binary64 field constants, the controller state enumeration and
// the result flag bundle. Imported by fp64_unpack and fp64_to_int_iter.
package fp64_to_int_iter_pkg;

  localparam int EXP_W  = 11;
  localparam int FRAC_W = 52;
  localparam int BIAS   = 1023;
  localparam int MANT_W = FRAC_W + 1;   // significand with hidden 1
  localparam int CNT_W  = 7;            // holds shift counts up to 63

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic overflow;
    logic invalid;
    logic inexact;
  } flags_t;

endpackage

// File: rtl/fp64_unpack.sv
// Combinational binary64 field extraction and classification.
// Ports: bits (operand) in; sign, mant (1.fr), special (resolve without
// shifting), special_val/special_flags (result for specials), shift_left and
// shift_cnt (direction and distance to align the significand) out.
module fp64_unpack
  import fp64_to_int_iter_pkg::*;
#(
  parameter int OUT_W = 64
) (
  input  logic [63:0]       bits,
  output logic              sign,
  output logic [MANT_W-1:0] mant,
  output logic              special,
  output logic [OUT_W-1:0]  special_val,
  output flags_t            special_flags,
  output logic              shift_left,
  output logic [CNT_W-1:0]  shift_cnt
);

  localparam logic signed [EXP_W+1:0] E_MAX  = (EXP_W+2)'(OUT_W - 1);
  localparam logic signed [EXP_W+1:0] E_PT   = (EXP_W+2)'(FRAC_W);
  localparam logic signed [EXP_W+1:0] E_BIAS = (EXP_W+2)'(BIAS);

  logic [EXP_W-1:0]         ex;
  logic [FRAC_W-1:0]        fr;
  logic signed [EXP_W+1:0]  e;
  logic                     frac_nz;
  logic [OUT_W-1:0]         sat_pos;
  logic [OUT_W-1:0]         sat_neg;

  assign sign    = bits[63];
  assign ex      = bits[62:52];
  assign fr      = bits[51:0];
  assign frac_nz = |fr;
  assign e       = $signed({2'b00, ex}) - E_BIAS;
  assign mant    = {1'b1, fr};
  assign sat_pos = {1'b0, {(OUT_W-1){1'b1}}};
  assign sat_neg = {1'b1, {(OUT_W-1){1'b0}}};

  always_comb begin
    special       = 1'b1;
    special_val   = '0;
    special_flags = '0;
    shift_left    = 1'b0;
    shift_cnt     = '0;
    if (ex == '1) begin
      if (frac_nz) begin
        special_flags.invalid = 1'b1;
      end else begin
        special_val            = sign ? sat_neg : sat_pos;
        special_flags.overflow = 1'b1;
      end
    end else if (ex == '0) begin
      // zero or subnormal: magnitude below 1
      special_flags.inexact = frac_nz;
    end else if (e < 0) begin
      special_flags.inexact = 1'b1;
    end else if (e >= E_MAX) begin
      // -2^(OUT_W-1) is the one representable value at this exponent
      if (sign && (e == E_MAX) && !frac_nz) begin
        special_val = sat_neg;
      end else begin
        special_val            = sign ? sat_neg : sat_pos;
        special_flags.overflow = 1'b1;
      end
    end else begin
      special = 1'b0;
      if (e >= E_PT) begin
        shift_left = 1'b1;
        shift_cnt  = CNT_W'(e - E_PT);
      end else begin
        shift_cnt  = CNT_W'(E_PT - e);
      end
    end
  end

endmodule

// File: rtl/fp64_to_int_iter.sv
// Iterative binary64 -> OUT_W-bit signed integer conversion, truncating toward zero.
// Ports: clock/reset (sync, active-high); in_valid/in_ready/in_bits operand
// handshake; out_valid/out_ready/out_bits plus overflow/invalid/inexact flags.
// Alignment shifts at most STEP bits per cycle; one operand in flight at a time.
module fp64_to_int_iter
  import fp64_to_int_iter_pkg::*;
#(
  parameter int OUT_W = 64,
  parameter int STEP  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_bits,
  output logic             out_overflow,
  output logic             out_invalid,
  output logic             out_inexact
);

  localparam int ACC_W = (OUT_W > MANT_W) ? OUT_W : MANT_W;

  logic              u_sign;
  logic [MANT_W-1:0] u_mant;
  logic              u_special;
  logic [OUT_W-1:0]  u_val;
  flags_t            u_flags;
  logic              u_left;
  logic [CNT_W-1:0]  u_cnt;

  fp64_unpack #(.OUT_W(OUT_W)) u_unpack (
    .bits          (in_bits),
    .sign          (u_sign),
    .mant          (u_mant),
    .special       (u_special),
    .special_val   (u_val),
    .special_flags (u_flags),
    .shift_left    (u_left),
    .shift_cnt     (u_cnt)
  );

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  rem;
  logic              dir_left;
  logic              neg;
  logic              sticky;
  flags_t            flags_q;

  logic [CNT_W-1:0]  amt;
  logic [ACC_W-1:0]  lost;
  logic [OUT_W-1:0]  result;

  assign amt    = (rem > CNT_W'(STEP)) ? CNT_W'(STEP) : rem;
  // The low amt bits moved to the top; nonzero means a right shift drops a 1.
  assign lost   = acc << (ACC_W - int'(amt));
  assign result = neg ? (~acc[OUT_W-1:0] + OUT_W'(1)) : acc[OUT_W-1:0];

  assign out_overflow = flags_q.overflow;
  assign out_invalid  = flags_q.invalid;
  assign out_inexact  = flags_q.inexact;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      rem       <= '0;
      dir_left  <= 1'b0;
      neg       <= 1'b0;
      sticky    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_bits  <= '0;
      flags_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            neg      <= u_sign;
            sticky   <= 1'b0;
            if (u_special) begin
              out_bits  <= u_val;
              flags_q   <= u_flags;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              acc      <= ACC_W'(u_mant);
              rem      <= u_cnt;
              dir_left <= u_left;
              state    <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (rem != '0) begin
            if (dir_left) begin
              acc <= acc << amt;
            end else begin
              acc <= acc >> amt;
              if (lost != '0) sticky <= 1'b1;
            end
            rem <= rem - amt;
          end else begin
            out_bits        <= result;
            flags_q         <= '0;
            flags_q.inexact <= sticky;
            out_valid       <= 1'b1;
            state           <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_bits  <= '0;
            flags_q   <= '0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp64_to_int_iter.sv
// Testbench for fp64_to_int_iter (OUT_W=64, STEP=8): directed cases plus
// randomized operands against an arithmetic reference model.
module tb_fp64_to_int_iter;

  localparam logic [63:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_bits;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_bits;
  logic        out_overflow;
  logic        out_invalid;
  logic        out_inexact;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  fp64_to_int_iter #(.OUT_W(64), .STEP(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_bits      (in_bits),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_bits     (out_bits),
    .out_overflow (out_overflow),
    .out_invalid  (out_invalid),
    .out_inexact  (out_inexact)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: truncating conversion computed from the value's exponent and significand.
  task automatic model(input logic [63:0] op, output logic [63:0] val,
                       output logic ov, output logic inv, output logic inx, output int lat);
    logic          s;
    int            ex;
    int            e;
    int            sh;
    logic [51:0]   fr;
    logic [127:0]  m;
    logic [127:0]  mag;
    s = op[63];
    ex = int'(op[62:52]);
    fr = op[51:0];
    e = ex - 1023;
    val = '0; ov = 1'b0; inv = 1'b0; inx = 1'b0; lat = 1;
    if (ex == 2047) begin
      if (fr != 0) inv = 1'b1;
      else begin val = s ? MINV : MAXV; ov = 1'b1; end
    end else if (ex == 0) begin
      inx = (fr != 0);
    end else if (e < 0) begin
      inx = 1'b1;
    end else if (e >= 63) begin
      if (s && e == 63 && fr == 0) val = MINV;
      else begin val = s ? MINV : MAXV; ov = 1'b1; end
    end else begin
      m = {75'd0, 1'b1, fr};
      if (e >= 52) begin
        sh = e - 52;
        mag = m << sh;
      end else begin
        sh = 52 - e;
        mag = m >> sh;
        inx = ((m & ((128'd1 << sh) - 128'd1)) != 0);
      end
      val = s ? (~mag[63:0] + 64'd1) : mag[63:0];
      lat = (sh + 7) / 8 + 2;
    end
  endtask

  // Runs one operand through; hold = cycles out_ready stays low in DONE,
  // junk = keep in_valid high with another operand while busy.
  task automatic convert(input logic [63:0] op, input int hold, input bit junk);
    logic [63:0] ev;
    logic        eo, ei, ex;
    int          el;
    int          lat;
    real         r;
    model(op, ev, eo, ei, ex, el);
    out_ready = (hold == 0);
    @(posedge clock); #1;
    check("in_ready_idle", 64'(in_ready), 64'd1);
    in_bits = op;
    in_valid = 1'b1;
    @(posedge clock); #1;
    if (junk) in_bits = ~op;
    else begin in_valid = 1'b0; in_bits = {$urandom, $urandom}; end
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      check("zero_when_invalid", {out_bits[62:0], out_overflow | out_invalid | out_inexact}, 64'd0);
      @(posedge clock); #1;
      lat++;
    end
    check("out_valid", 64'(out_valid), 64'd1);
    check("latency", 64'(lat), 64'(el));
    check("out_bits", out_bits, ev);
    check("flags", {61'd0, out_overflow, out_invalid, out_inexact}, {61'd0, eo, ei, ex});
    check("in_ready_busy", 64'(in_ready), 64'd0);
    r = $bitstoreal(op);
    if (op[62:52] != 11'h7FF && r < 2147483648.0 && r > -2147483648.0)
      check("rtoi_xcheck", out_bits, 64'(longint'($rtoi(r))));
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_bits", out_bits, ev);
      check("hold_flags", {61'd0, out_overflow, out_invalid, out_inexact}, {61'd0, eo, ei, ex});
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("after_valid", 64'(out_valid), 64'd0);
    check("after_in_ready", 64'(in_ready), 64'd1);
    check("after_bits", out_bits, 64'd0);
  endtask

  initial begin
    logic [63:0] rnd;
    logic [10:0] rex;
    logic [51:0] rfr;
    reset = 1'b1;
    in_valid = 1'b0;
    in_bits = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_bits", out_bits, 64'd0);
    check("rst_flags", {61'd0, out_overflow, out_invalid, out_inexact}, 64'd0);

    convert(64'h3FF0_0000_0000_0000, 0, 1'b0);  // 1.0
    convert(64'hC004_0000_0000_0000, 0, 1'b0);  // -2.5
    convert(64'h7FF8_0000_0000_0000, 0, 1'b0);  // NaN
    convert(64'h43E0_0000_0000_0000, 0, 1'b0);  // 2^63
    convert(64'hC3E0_0000_0000_0000, 0, 1'b0);  // -2^63
    convert(64'hC3E0_0000_0000_0001, 0, 1'b0);  // just below -2^63
    convert(64'h43D0_0000_0000_0000, 0, 1'b0);  // 2^62
    convert(64'h43DF_FFFF_FFFF_FFFF, 0, 1'b0);  // largest below 2^63
    convert(64'hFFF0_0000_0000_0000, 0, 1'b0);  // -inf
    convert(64'h0000_0000_0000_0000, 0, 1'b0);  // +0
    convert(64'h8000_0000_0000_0001, 0, 1'b0);  // negative subnormal
    convert(64'h3FE0_0000_0000_0000, 0, 1'b0);  // 0.5
    convert(64'h4330_0000_0000_0000, 0, 1'b0);  // 2^52, zero shift
    convert(64'hC004_0000_0000_0000, 5, 1'b0);  // held output
    convert(64'h4059_0000_0000_0000, 0, 1'b1);  // 100.0 with busy-time traffic

    // Reset in C3 of a 1.0 conversion.
    @(posedge clock); #1;
    in_bits = 64'h3FF0_0000_0000_0000;
    in_valid = 1'b1;
    @(posedge clock); #1;            // C1
    in_valid = 1'b0;
    @(posedge clock); #1;            // C2
    @(posedge clock); #1;            // C3
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_bits", out_bits, 64'd0);
    convert(64'h3FF0_0000_0000_0000, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      rnd = {$urandom, $urandom};
      rfr = rnd[51:0];
      if ($urandom_range(0, 3) == 0) rfr = '0;
      case ($urandom_range(0, 3))
        0: rex = 11'($urandom_range(1020, 1090));
        1: rex = rnd[62:52];
        2: rex = 11'($urandom_range(1075, 1086));
        default: rex = 11'($urandom_range(1023, 1045));
      endcase
      convert({rnd[63], rex, rfr}, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
              1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
